// File: rtl/axis_capture_sniffer.sv
// axis_capture_sniffer: transparent AXI4-Stream tap with triggered, optionally decimated snapshot capture
//   aclk/areset          : clock, asynchronous active-high reset
//   S_AXIS_* / M_AXIS_*  : combinational pass-through, never stalled by the tap
//   t_data               : last handshaked beat, registered
//   arm/trigger/decim    : capture control; decim keeps 1 of every decim+1 beats
//   state/count          : 0 IDLE, 1 ARMED, 2 CAPTURE, 3 DONE; number of samples stored
//   rd_addr/rd_data      : synchronous buffer readout, one cycle latency
//   Define AXIS_CAPTURE_SNIFFER_DECIMATION_EN to build the decimation counter.
module axis_capture_sniffer #(
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int DEPTH_LOG2 = 8,
    parameter int DECIM_WIDTH = 16
) (
    input  logic                        aclk,
    input  logic                        areset,
    input  logic                        S_AXIS_tvalid,
    input  logic [AXIS_TDATA_WIDTH-1:0] S_AXIS_tdata,
    output logic                        S_AXIS_tready,
    input  logic                        M_AXIS_tready,
    output logic                        M_AXIS_tvalid,
    output logic [AXIS_TDATA_WIDTH-1:0] M_AXIS_tdata,
    output logic [AXIS_TDATA_WIDTH-1:0] t_data,
    input  logic                        arm,
    input  logic                        trigger,
    input  logic [DECIM_WIDTH-1:0]      decim,
    output logic [1:0]                  state,
    output logic [DEPTH_LOG2:0]         count,
    input  logic [DEPTH_LOG2-1:0]       rd_addr,
    output logic [AXIS_TDATA_WIDTH-1:0] rd_data
);
    typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, CAPTURE = 2'd2, DONE = 2'd3} state_t;
    localparam int DEPTH = 1 << DEPTH_LOG2;
    state_t                      r_state;
    logic [DEPTH_LOG2:0]         r_count;
    logic [AXIS_TDATA_WIDTH-1:0] r_t_data;
    logic [AXIS_TDATA_WIDTH-1:0] r_rd_data;
    logic [AXIS_TDATA_WIDTH-1:0] r_buf [DEPTH];
    logic                        w_beat;
    logic                        w_keep;
    logic                        w_wr;
    logic                        w_last;
    assign S_AXIS_tready = M_AXIS_tready;
    assign M_AXIS_tvalid = S_AXIS_tvalid;
    assign M_AXIS_tdata  = S_AXIS_tdata;
    assign t_data        = r_t_data;
    assign rd_data       = r_rd_data;
    assign state         = r_state;
    assign count         = r_count;
    assign w_beat        = S_AXIS_tvalid && M_AXIS_tready;
`ifdef AXIS_CAPTURE_SNIFFER_DECIMATION_EN
    logic [DECIM_WIDTH-1:0] r_decim;
    logic [DECIM_WIDTH-1:0] r_dcnt;
    assign w_keep = r_dcnt == '0;
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_decim <= '0;
            r_dcnt  <= '0;
        end else if (arm) begin
            r_decim <= decim;
            r_dcnt  <= '0;
        end else if (r_state == CAPTURE && w_beat) begin
            r_dcnt  <= (r_dcnt == r_decim) ? '0 : r_dcnt + 1'b1;
        end
    end
`else
    logic w_unused_decim;
    assign w_unused_decim = ^decim;
    assign w_keep = 1'b1;
`endif
    // arm wins over a same-cycle write so a restart never stores a stale sample
    assign w_wr   = !arm && r_state == CAPTURE && w_beat && w_keep;
    assign w_last = r_count == (DEPTH_LOG2 + 1)'(DEPTH - 1);
    // buffer contents are deliberately not reset
    always_ff @(posedge aclk) begin
        if (w_wr) r_buf[r_count[DEPTH_LOG2-1:0]] <= S_AXIS_tdata;
    end
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state   <= IDLE;
            r_count   <= '0;
            r_t_data  <= '0;
            r_rd_data <= '0;
        end else begin
            if (w_beat) r_t_data <= S_AXIS_tdata;
            r_rd_data <= r_buf[rd_addr];
            if (arm) begin
                r_state <= ARMED;
                r_count <= '0;
            end else if (r_state == ARMED && trigger) begin
                r_state <= CAPTURE;
            end else if (w_wr) begin
                r_count <= r_count + 1'b1;
                if (w_last) r_state <= DONE;
            end
        end
    end
endmodule

// File: tb/tb_axis_capture_sniffer.sv
// tb_axis_capture_sniffer: directed self-checking bench for axis_capture_sniffer with an 8-deep buffer
module tb_axis_capture_sniffer;
`ifdef AXIS_CAPTURE_SNIFFER_DECIMATION_EN
    localparam int STRIDE_D2 = 3;
`else
    localparam int STRIDE_D2 = 1;
`endif
    logic        aclk = 0;
    logic        areset = 1;
    logic        S_AXIS_tvalid = 0;
    logic [31:0] S_AXIS_tdata = 0;
    logic        S_AXIS_tready;
    logic        M_AXIS_tready = 1;
    logic        M_AXIS_tvalid;
    logic [31:0] M_AXIS_tdata;
    logic [31:0] t_data;
    logic        arm = 0;
    logic        trigger = 0;
    logic [15:0] decim = 0;
    logic [1:0]  state;
    logic [3:0]  count;
    logic [2:0]  rd_addr = 0;
    logic [31:0] rd_data;
    int          total = 0;
    int          passed = 0;
    int          fails = 0;

    axis_capture_sniffer #(.AXIS_TDATA_WIDTH(32), .DEPTH_LOG2(3), .DECIM_WIDTH(16)) dut (
        .aclk(aclk), .areset(areset),
        .S_AXIS_tvalid(S_AXIS_tvalid), .S_AXIS_tdata(S_AXIS_tdata), .S_AXIS_tready(S_AXIS_tready),
        .M_AXIS_tready(M_AXIS_tready), .M_AXIS_tvalid(M_AXIS_tvalid), .M_AXIS_tdata(M_AXIS_tdata),
        .t_data(t_data), .arm(arm), .trigger(trigger), .decim(decim),
        .state(state), .count(count), .rd_addr(rd_addr), .rd_data(rd_data)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge aclk);
        #1;
    endtask

    task automatic start_capture(input logic [15:0] d);
        decim = d;
        arm = 1;
        S_AXIS_tdata = 90;
        step;
        arm = 0;
        decim = 16'hffff;
        chk("armed_state", 32'(state), 1);
        chk("armed_count", 32'(count), 0);
        trigger = 1;
        S_AXIS_tdata = 99;
        step;
        trigger = 0;
        chk("capture_state", 32'(state), 2);
        chk("capture_count", 32'(count), 0);
    endtask

    task automatic readout(input int base, input int stride, input string tag);
        for (int a = 0; a < 8; a++) begin
            rd_addr = 3'(a);
            step;
            chk(tag, rd_data, 32'(base + a * stride));
        end
    endtask

    task automatic capture_run(input logic [15:0] d, input int stride);
        int n = 0;
        start_capture(d);
        while (state != 2'd3 && n < 100) begin
            S_AXIS_tdata = 32'(100 + n);
            n++;
            step;
            if (n == 1) chk("first_count", 32'(count), 1);
        end
        chk("done_state", 32'(state), 3);
        chk("done_count", 32'(count), 8);
        chk("beats_used", 32'(n), 32'(7 * stride + 1));
        readout(100, stride, "rd_stride");
    endtask

    initial begin
        int n;
        S_AXIS_tdata = 32'h55;
        step;
        chk("rst_pass", M_AXIS_tdata, 32'h55);
        chk("rst_state", 32'(state), 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_tdata", t_data, 0);
        chk("rst_rddata", rd_data, 0);
        areset = 0;
        for (int k = 1; k <= 5; k++) begin
            S_AXIS_tdata = 32'(k);
            S_AXIS_tvalid = 1;
            #1;
            chk("pass_data", M_AXIS_tdata, 32'(k));
            chk("pass_valid", 32'(M_AXIS_tvalid), 1);
            step;
            chk("tdata_lag", t_data, 32'(k));
            chk("idle_state", 32'(state), 0);
            chk("idle_count", 32'(count), 0);
        end
        S_AXIS_tvalid = 0;
        S_AXIS_tdata = 77;
        step;
        chk("novalid_pass", 32'(M_AXIS_tvalid), 0);
        chk("novalid_hold", t_data, 5);
        S_AXIS_tvalid = 1;
        capture_run(0, 1);
        capture_run(2, STRIDE_D2);
        start_capture(0);
        n = 0;
        while (state != 2'd3 && n < 100) begin
            S_AXIS_tdata = 32'(200 + n);
            M_AXIS_tready = (n % 2) == 0;
            #1;
            chk("sready_follow", 32'(S_AXIS_tready), 32'((n % 2) == 0));
            n++;
            step;
        end
        M_AXIS_tready = 1;
        chk("toggle_done", 32'(state), 3);
        chk("toggle_count", 32'(count), 8);
        readout(200, 2, "rd_toggle");
        start_capture(0);
        n = 0;
        while (count != 4'd7 && n < 100) begin
            S_AXIS_tdata = 32'(300 + n);
            n++;
            step;
        end
        chk("pre_last_state", 32'(state), 2);
        S_AXIS_tdata = 32'd399;
        arm = 1;
        step;
        arm = 0;
        chk("rearm_state", 32'(state), 1);
        chk("rearm_count", 32'(count), 0);
        trigger = 1;
        step;
        trigger = 0;
        for (int k = 0; k < 5; k++) begin
            S_AXIS_tdata = 32'(500 + k);
            step;
        end
        chk("mid_state", 32'(state), 2);
        chk("mid_count", 32'(count), 5);
        areset = 1;
        step;
        chk("abort_state", 32'(state), 0);
        chk("abort_count", 32'(count), 0);
        chk("abort_tdata", t_data, 0);
        areset = 0;
        trigger = 1;
        for (int k = 0; k < 3; k++) begin
            S_AXIS_tdata = 32'(600 + k);
            step;
        end
        trigger = 0;
        chk("trig_only_state", 32'(state), 0);
        chk("trig_only_count", 32'(count), 0);
        chk("post_rst_tdata", t_data, 602);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/axis_capture_sniffer.md
# axis_capture_sniffer

Transparent AXI4-Stream tap with triggered snapshot capture. Passes the stream unmodified from slave to master and exposes the live sample, like the plain sniffer. On command it records a block of `2**DEPTH_LOG2` handshaked beats into an internal buffer, optionally decimated, for readout over a simple synchronous read port. It sits between the acquisition pipeline stages so software can inspect a frozen window of any intermediate signal.

## Interface
Parameters:
- `AXIS_TDATA_WIDTH`, 32, stream and sample width
- `DEPTH_LOG2`, 8, log2 of capture depth (256 samples)
- `DECIM_WIDTH`, 16, width of decimation ratio

Ports:
- `aclk` in 1: single clock; everything is synchronous to its rising edge
- `areset` in 1: reset, asynchronous, active-high
- `S_AXIS_tvalid` in 1: upstream valid
- `S_AXIS_tdata` in AXIS_TDATA_WIDTH: upstream data
- `S_AXIS_tready` out 1: equals `M_AXIS_tready`
- `M_AXIS_tready` in 1: downstream ready
- `M_AXIS_tvalid` out 1: equals `S_AXIS_tvalid`
- `M_AXIS_tdata` out AXIS_TDATA_WIDTH: equals `S_AXIS_tdata`
- `t_data` out AXIS_TDATA_WIDTH: last handshaked beat, registered
- `arm` in 1: single-cycle pulse that starts or restarts a capture
- `trigger` in 1: level; starts recording while armed
- `decim` in DECIM_WIDTH: keep 1 of every `decim+1` beats
- `state` out 2: 0 IDLE, 1 ARMED, 2 CAPTURE, 3 DONE
- `count` out DEPTH_LOG2+1: number of samples stored
- `rd_addr` in DEPTH_LOG2: buffer read address
- `rd_data` out AXIS_TDATA_WIDTH: buffer word at `rd_addr`, registered

## Operation
- Pass-through is purely combinational and does not depend on reset, state, or capture activity. The tap never stalls the stream.
- A beat is a cycle with `S_AXIS_tvalid && M_AXIS_tready`. On every beat, `t_data` loads `S_AXIS_tdata`.
- State machine behaviour:
  - IDLE or DONE, with `arm`: go to ARMED. Clear `count`, clear the decimation counter, and latch `decim`.
  - ARMED, with `trigger`=1 and no `arm`: go to CAPTURE. The beat in that same cycle is not stored.
  - CAPTURE, on each beat: if the decimation counter is 0, write the beat to `buf[count]` and increment `count`. The counter advances modulo `decim_latched+1`.
  - CAPTURE, on the write that makes `count` equal `2**DEPTH_LOG2`: go to DONE on the same edge.
  - `arm` in ARMED, CAPTURE or DONE: restart as from IDLE. `arm` takes priority over `trigger` and over completion in the same cycle.
- In CAPTURE, `trigger` is ignored, and cycles without a beat change nothing.
- `count` width is DEPTH_LOG2+1, so a full buffer reads exactly `2**DEPTH_LOG2`.
- `rd_data` updates every cycle from `buf[rd_addr]`. Reads during CAPTURE return whatever is currently stored; there is no read/write collision hazard beyond that.

## Timing
- Reset values: `state`=IDLE, `count`=0, `t_data`=0, `rd_data`=0, decimation counter 0, latched `decim` 0. Buffer contents are not reset and are undefined.
- Assertion of `areset` mid-capture aborts to IDLE immediately. The capture is not resumed.
- Latencies:
  - `arm` → `state`=ARMED: 1 cycle.
  - `trigger` → CAPTURE: 1 cycle.
  - Beat → `count` increment: 1 cycle.
  - `rd_addr` → `rd_data`: 1 cycle.
- The first sample stored is the first beat whose cycle begins in CAPTURE.
- Changes to `decim` after `arm` have no effect until the next `arm`.

## Configuration
- Macro: `AXIS_CAPTURE_SNIFFER_DECIMATION_EN`.
- Defined: decimation operates as described above.
- Undefined: the `decim` port remains but is ignored, and no decimation counter is built. Every beat in CAPTURE is stored, which is equivalent to `decim`=0.

## Test plan
- Reset, then a beat stream of 1,2,3… with constant ready; no arm issued → `M_AXIS_tdata` mirrors the input; `state`=0, `count`=0; `t_data` lags the input by one cycle.
- `arm`, then `trigger` one cycle later, continuous beats from value 100, `decim`=0, DEPTH_LOG2=3 → `state` goes 1,2,3; `count`=8; `rd_addr` 0..7 returns the first 8 beats that arrive in CAPTURE, in order and consecutive.
- Same setup with `decim`=2 (macro defined) → the stored values step by 3. With the macro undefined → the stored values step by 1.
- During CAPTURE, toggle `M_AXIS_tready` 50% → only handshaked beats are stored, with no duplicates; `S_AXIS_tready` follows `M_AXIS_tready` combinationally.
- `arm` asserted in the cycle the last sample is written → `state`=ARMED, `count`=0, not DONE.
- Assert `areset` while `count`=5 in CAPTURE → next cycle `state`=0 and `count`=0; `trigger` alone without `arm` does not restart capture.
